// File: rtl/pll_lock_rst_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_rst_gen_pkg
// Description : Shared types and constants for the PLL lock reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_lock_rst_gen_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'b00,
      ST_QUAL = 2'b01,
      ST_RUN  = 2'b10,
      ST_SOFT = 2'b11
   } state_t;

   localparam int c_LOSS_CNT_W = 8;
   localparam int c_CNT_W      = 16;

   function automatic logic [c_LOSS_CNT_W-1:0] sat_inc(input logic [c_LOSS_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_rst_gen_lock_sync.sv
`default_nettype none
// ============================================================================
// Module      : lock_sync
// Description : STAGES-deep single-bit synchronizer with async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_rst_gen.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_rst_gen
// Description : Qualifies PLL lock and sequences the GL0 system reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_rst_gen
   import pll_lock_rst_gen_pkg::*;
#(
   parameter int LOCK_STABLE_CYC = 1024,
   parameter int SOFT_RST_CYC    = 16,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pll_lock,
   input  logic                    soft_rst_req,
   input  logic                    clr_diag,
   output logic                    sys_rst_n,
   output logic                    lock_ok,
   output logic                    loss_sticky,
   output logic [c_LOSS_CNT_W-1:0] loss_cnt
);

   localparam logic [c_CNT_W-1:0] c_QUAL_LAST = c_CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_SOFT_LAST = c_CNT_W'(SOFT_RST_CYC - 1);

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               w_lock_s;
   logic               w_loss;

   lock_sync #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (w_lock_s)
   );

   assign w_loss = (r_state == ST_RUN) && !w_lock_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_HOLD;
         r_cnt       <= '0;
         sys_rst_n   <= 1'b0;
         lock_ok     <= 1'b0;
         loss_sticky <= 1'b0;
         loss_cnt    <= '0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               r_cnt     <= '0;
               sys_rst_n <= 1'b0;
               lock_ok   <= 1'b0;
               if (w_lock_s) r_state <= ST_QUAL;
            end
            ST_QUAL: begin
               if (!w_lock_s) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
               end else if (r_cnt == c_QUAL_LAST) begin
                  r_state   <= ST_RUN;
                  r_cnt     <= '0;
                  sys_rst_n <= 1'b1;
                  lock_ok   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               // Lock loss takes priority over a coincident soft request.
               if (!w_lock_s) begin
                  r_state   <= ST_HOLD;
                  sys_rst_n <= 1'b0;
                  lock_ok   <= 1'b0;
               end else if (soft_rst_req) begin
                  r_state   <= ST_SOFT;
                  r_cnt     <= '0;
                  sys_rst_n <= 1'b0;
                  lock_ok   <= 1'b0;
               end
            end
            ST_SOFT: begin
               if (!w_lock_s) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
               end else if (r_cnt == c_SOFT_LAST) begin
                  r_state <= ST_QUAL;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= ST_HOLD;
               r_cnt     <= '0;
               sys_rst_n <= 1'b0;
               lock_ok   <= 1'b0;
            end
         endcase

         // A loss in the same cycle as a clear wins: counts as first event.
         if (w_loss) begin
            loss_sticky <= 1'b1;
            loss_cnt    <= clr_diag ? c_LOSS_CNT_W'(1) : sat_inc(loss_cnt);
         end else if (clr_diag) begin
            loss_sticky <= 1'b0;
            loss_cnt    <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_rst_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_rst_gen
// Description : Self-checking bench for pll_lock_rst_gen with run-length model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_rst_gen;

   localparam int LSC  = 8;
   localparam int SRC  = 4;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_lock = 1'b1;
   logic       soft_rst_req = 1'b0;
   logic       clr_diag = 1'b0;
   logic       sys_rst_n;
   logic       lock_ok;
   logic       loss_sticky;
   logic [7:0] loss_cnt;

   int checks = 0;
   int failures = 0;

   pll_lock_rst_gen #(
      .LOCK_STABLE_CYC (LSC),
      .SOFT_RST_CYC    (SRC),
      .SYNC_STAGES     (SYNC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_lock     (pll_lock),
      .soft_rst_req (soft_rst_req),
      .clr_diag     (clr_diag),
      .sys_rst_n    (sys_rst_n),
      .lock_ok      (lock_ok),
      .loss_sticky  (loss_sticky),
      .loss_cnt     (loss_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: release needs a run of consecutive synchronized-lock
   // samples; after a soft request the run restarts with a different length.
   bit       m_hist [SYNC];
   bit       m_run;
   int       m_len;
   int       m_need;
   bit       m_sticky;
   int       m_cnt;

   always @(posedge clk or negedge rst_n) begin
      bit lk;
      bit loss;
      if (!rst_n) begin
         for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
         m_run = 0; m_len = 0; m_need = LSC + 1; m_sticky = 0; m_cnt = 0;
      end else begin
         lk   = m_hist[SYNC-1];
         loss = 1'b0;
         if (!lk) begin
            loss = m_run; m_run = 0; m_len = 0; m_need = LSC + 1;
         end else if (m_run) begin
            if (soft_rst_req) begin
               m_run = 0; m_len = 0; m_need = SRC + LSC;
            end
         end else begin
            m_len++;
            if (m_len >= m_need) m_run = 1;
         end
         if (loss) begin
            m_sticky = 1;
            m_cnt = clr_diag ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
         end else if (clr_diag) begin
            m_sticky = 0; m_cnt = 0;
         end
         for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = pll_lock;
      end
   end

   function automatic logic [10:0] dut_vec();
      return {sys_rst_n, lock_ok, loss_sticky, loss_cnt};
   endfunction

   function automatic logic [10:0] mdl_vec();
      return {m_run, m_run, m_sticky, 8'(m_cnt)};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; pll_lock = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== 11'h000) begin
            failures++;
            $display("FAIL reset_state: dut=%h expected=000", dut_vec());
         end
      end
   endtask

   task automatic test_powerup();
      int rise = 0;
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL powerup_cycle %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
         end
         if (sys_rst_n && rise == 0) rise = k;
      end
      checks++;
      if (rise != 11 || lock_ok !== 1'b1 || loss_cnt !== 8'd0) begin
         failures++;
         $display("FAIL powerup_release: rise=%0d lock_ok=%b cnt=%0d expected rise=11 lock_ok=1 cnt=0",
                  rise, lock_ok, loss_cnt);
      end
   endtask

   task automatic test_chatter();
      int rise = 0;
      pll_lock = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      pll_lock = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL chatter_cycle %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
         end
         pll_lock = (k != 4);
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL chatter_settle %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
         end
         if (sys_rst_n && rise == 0) rise = k;
      end
      checks++;
      if (rise != 11 || loss_sticky !== 1'b0) begin
         failures++;
         $display("FAIL chatter_release: rise=%0d sticky=%b expected rise=11 sticky=0", rise, loss_sticky);
      end
   endtask

   task automatic test_loss();
      for (int n = 0; n < 3; n++) begin
         int lat = 0;
         int w = 0;
         pll_lock = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
               failures++;
               $display("FAIL loss_cycle %0d/%0d: dut=%h model=%h", n, k, dut_vec(), mdl_vec());
            end
            if (!sys_rst_n && lat == 0) lat = k;
         end
         checks++;
         if (lat == 0 || lat > 3) begin
            failures++;
            $display("FAIL loss_latency %0d: got=%0d expected<=3", n, lat);
         end
         pll_lock = 1'b1;
         while (!lock_ok && w < 30) begin
            @(negedge clk); w++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
               failures++;
               $display("FAIL loss_recover %0d: dut=%h model=%h", n, dut_vec(), mdl_vec());
            end
         end
      end
      checks++;
      if (loss_cnt !== 8'd3 || loss_sticky !== 1'b1) begin
         failures++;
         $display("FAIL loss_diag: cnt=%0d sticky=%b expected cnt=3 sticky=1", loss_cnt, loss_sticky);
      end
      clr_diag = 1'b1;
      @(negedge clk);
      clr_diag = 1'b0;
      checks++;
      if (loss_cnt !== 8'd0 || loss_sticky !== 1'b0) begin
         failures++;
         $display("FAIL loss_clear: cnt=%0d sticky=%b expected cnt=0 sticky=0", loss_cnt, loss_sticky);
      end
   endtask

   task automatic test_soft();
      int low = 0;
      soft_rst_req = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         soft_rst_req = 1'b0;
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL soft_cycle %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
         end
         if (!sys_rst_n) low++;
         else if (low > 0) break;
      end
      checks++;
      if (low != 12 || lock_ok !== 1'b1 || loss_cnt !== 8'd0 || loss_sticky !== 1'b0) begin
         failures++;
         $display("FAIL soft_window: low=%0d lock_ok=%b cnt=%0d sticky=%b expected 12/1/0/0",
                  low, lock_ok, loss_cnt, loss_sticky);
      end
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 260; n++) begin
         int w = 0;
         pll_lock = 1'b0;
         repeat (3) @(negedge clk);
         pll_lock = 1'b1;
         while (!lock_ok && w < 30) begin
            @(negedge clk); w++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
               failures++;
               $display("FAIL sat_cycle %0d: dut=%h model=%h", n, dut_vec(), mdl_vec());
            end
         end
      end
      checks++;
      if (loss_cnt !== 8'd255 || loss_sticky !== 1'b1) begin
         failures++;
         $display("FAIL saturation: cnt=%0d sticky=%b expected cnt=255 sticky=1", loss_cnt, loss_sticky);
      end
   endtask

   task automatic test_collision();
      bit hit = 0;
      int w = 0;
      pll_lock = 1'b0;
      for (int k = 0; k < 10 && !hit; k++) begin
         @(negedge clk);
         if (m_run && !m_hist[SYNC-1]) begin
            clr_diag = 1'b1;
            hit = 1;
         end
      end
      @(negedge clk);
      clr_diag = 1'b0;
      checks++;
      if (!hit || loss_cnt !== 8'd1 || loss_sticky !== 1'b1) begin
         failures++;
         $display("FAIL collision: hit=%0b cnt=%0d sticky=%b expected cnt=1 sticky=1", hit, loss_cnt, loss_sticky);
      end
      pll_lock = 1'b1;
      while (!lock_ok && w < 30) begin
         @(negedge clk); w++;
      end
      checks++;
      if (!lock_ok) begin
         failures++;
         $display("FAIL collision_recover: lock_ok=%b expected 1", lock_ok);
      end
   endtask

   task automatic test_async_reset();
      int rise = 0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 11'h000) begin
         failures++;
         $display("FAIL async_run_clear: dut=%h expected=000", dut_vec());
      end
      @(negedge clk); rst_n = 1'b1;
      // QUAL entered at edge 3; counter reaches 5 at edge 8.
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 11'h000) begin
         failures++;
         $display("FAIL async_qual_clear: dut=%h expected=000", dut_vec());
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL async_requal %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
         end
         if (sys_rst_n && rise == 0) rise = k;
      end
      checks++;
      if (rise != 11) begin
         failures++;
         $display("FAIL async_release: rise=%0d expected 11", rise);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL random_cycle %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
         end
         pll_lock     = ($urandom_range(0, 19) != 0);
         soft_rst_req = ($urandom_range(0, 15) == 0);
         clr_diag     = ($urandom_range(0, 31) == 0);
      end
      pll_lock = 1'b1; soft_rst_req = 1'b0; clr_diag = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_powerup();
      test_chatter();
      test_loss();
      test_soft();
      test_saturation();
      test_collision();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
